// File: rtl/vector_chain_accumulator_pkg.sv
// Shared encodings for the per-chain vector accumulator.
// Op codes, config byte offsets and small helpers.
package vector_chain_accumulator_pkg;

  typedef enum logic [7:0] {
    OP_PASS = 8'd0,
    OP_SUM  = 8'd1,
    OP_MAX  = 8'd2
  } op_e;

  localparam int DEF_MAX_CHAINS = 4;

  localparam int CFG_OP_BASE = 0;
  localparam int CFG_WINDOW_BASE = DEF_MAX_CHAINS;

  function automatic int cfg_window_base(
    input int chains
  );
    return CFG_OP_BASE + chains;
  endfunction

  function automatic logic is_fold_op(
    input logic [7:0] op
  );
    return (op == OP_SUM) || (op == OP_MAX);
  endfunction

  function automatic logic [7:0] eff_window(
    input logic [7:0] w
  );
    return (w == 8'd0) ? 8'd1 : w;
  endfunction

endpackage

// File: rtl/vector_chain_accumulator_lane_combine.sv
// Lane-wise fold of one input vector into an accumulator.
// Start loads the vector; otherwise SUM wraps, MAX is unsigned.
module lane_combine
  import vector_chain_accumulator_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] acc,
  input  logic [N-1:0][DATA_WIDTH-1:0] vec,
  input  logic [7:0]                   op,
  input  logic                         start,
  output logic [N-1:0][DATA_WIDTH-1:0] nxt
);

  // per-lane combine, no state
  always_comb begin
    nxt = '0;
    for (int i = 0; i < N; i++) begin
      if (start) begin
        nxt[i] = vec[i];
      end else if (op == OP_MAX) begin
        nxt[i] = (vec[i] > acc[i]) ? vec[i] : acc[i];
      end else begin
        nxt[i] = acc[i] + vec[i];
      end
    end
  end

endmodule

// File: rtl/vector_chain_accumulator.sv
// Per-chain SUM/MAX accumulator over frame windows, bypassable.
// Configured per chain through the shared configId/configData stream.
module vector_chain_accumulator
  import vector_chain_accumulator_pkg::*;
#(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd1,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_WINDOW =
    {MAX_CHAINS{8'd1}},
  localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tracing,
  input  logic                         valid_in,
  input  logic                         bof_in,
  input  logic                         eof_in,
  input  logic [CW-1:0]                chainId_in,
  input  logic [7:0]                   configId,
  input  logic [7:0]                   configData,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic [CW-1:0]                chainId_out,
  output logic                         valid_out,
  output logic                         bof_out,
  output logic                         eof_out
);

  localparam int WIN_BASE = cfg_window_base(MAX_CHAINS);

  logic [7:0] op_q   [MAX_CHAINS];
  logic [7:0] win_q  [MAX_CHAINS];
  logic [7:0] fcnt_q [MAX_CHAINS];
  logic [N-1:0][DATA_WIDTH-1:0] acc_q [MAX_CHAINS];
  logic [7:0] byte_cnt;

  logic [CW-1:0] ch;
  logic [7:0] cur_op;
  logic [7:0] cur_win;
  logic [7:0] cur_cnt;
  logic [7:0] cnt_inc;
  logic [N-1:0][DATA_WIDTH-1:0] cur_acc;
  logic [N-1:0][DATA_WIDTH-1:0] nxt_acc;
  logic fold;
  logic start;
  logic acc_go;
  logic pass_go;
  logic emit;
  logic cfg_en;
  logic [MAX_CHAINS-1:0] op_hit;
  logic [MAX_CHAINS-1:0] win_hit;

  // decode the incoming vector against its chain's state
  always_comb begin
    ch      = chainId_in;
    cur_op  = op_q[ch];
    cur_win = win_q[ch];
    cur_cnt = fcnt_q[ch];
    cur_acc = acc_q[ch];
    fold    = is_fold_op(cur_op);
    start   = bof_in && (cur_cnt == 8'd0);
    cnt_inc = cur_cnt + 8'd1;
    acc_go  = tracing && valid_in && fold;
    pass_go = tracing && valid_in && !fold;
    emit    = acc_go && eof_in &&
              (cnt_inc >= eff_window(cur_win));
    cfg_en  = !tracing &&
              (configId == PERSONAL_CONFIG_ID);
  end

  // which chain the current config byte lands on, if any
  always_comb begin
    op_hit  = '0;
    win_hit = '0;
    for (int c = 0; c < MAX_CHAINS; c++) begin
      op_hit[c]  = cfg_en &&
                   (byte_cnt == 8'(CFG_OP_BASE + c));
      win_hit[c] = cfg_en &&
                   (byte_cnt == 8'(WIN_BASE + c));
    end
  end

  lane_combine #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_combine (
    .acc   (cur_acc),
    .vec   (vector_in),
    .op    (cur_op),
    .start (start),
    .nxt   (nxt_acc)
  );

  // config byte position; saturates so late bytes never alias
  always_ff @(posedge clk) begin
    if (!resetn) begin
      byte_cnt <= 8'd0;
    end else if (cfg_en) begin
      if (byte_cnt != 8'hFF) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
    end else begin
      byte_cnt <= 8'd0;
    end
  end

  // firmware registers: op and window bytes per chain
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        op_q[c]  <= INITIAL_FIRMWARE_OP[c*8 +: 8];
        win_q[c] <= INITIAL_FIRMWARE_WINDOW[c*8 +: 8];
      end
    end else begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        if (op_hit[c]) begin
          op_q[c] <= configData;
        end
        if (win_hit[c]) begin
          win_q[c] <= configData;
        end
      end
    end
  end

  // accumulators and frame counters per chain
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        acc_q[c]  <= '0;
        fcnt_q[c] <= 8'd0;
      end
    end else begin
      for (int c = 0; c < MAX_CHAINS; c++) begin
        if (op_hit[c] || win_hit[c]) begin
          acc_q[c]  <= '0;
          fcnt_q[c] <= 8'd0;
        end else if (acc_go && (ch == CW'(c))) begin
          if (emit) begin
            acc_q[c]  <= '0;
            fcnt_q[c] <= 8'd0;
          end else begin
            acc_q[c] <= nxt_acc;
            if (eof_in) begin
              fcnt_q[c] <= cnt_inc;
            end
          end
        end
      end
    end
  end

  // output register; payload holds while valid_out is low
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vector_out  <= '0;
      chainId_out <= '0;
      valid_out   <= 1'b0;
      bof_out     <= 1'b0;
      eof_out     <= 1'b0;
    end else begin
      valid_out <= pass_go || emit;
      if (pass_go) begin
        vector_out  <= vector_in;
        chainId_out <= chainId_in;
        bof_out     <= bof_in;
        eof_out     <= eof_in;
      end else if (emit) begin
        vector_out  <= nxt_acc;
        chainId_out <= chainId_in;
        bof_out     <= 1'b1;
        eof_out     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_chain_accumulator.sv
// Bench for vector_chain_accumulator: directed table, corner
// sequences and random traffic against a queue-based model.
module tb_vector_chain_accumulator;

  typedef logic [7:0][31:0] vec_t;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic       b;
    logic       e;
    vec_t       vec;
    logic       ev;
    vec_t       evec;
    logic       eb;
    logic       ee;
  } vrec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tracing;
  logic       valid_in, bof_in, eof_in;
  logic [1:0] chainId_in;
  logic [7:0] configId, configData;
  vec_t       vector_in;
  vec_t       vector_out;
  logic [1:0] chainId_out;
  logic       valid_out, bof_out, eof_out;

  vector_chain_accumulator dut (
    .clk         (clk),
    .resetn      (resetn),
    .tracing     (tracing),
    .valid_in    (valid_in),
    .bof_in      (bof_in),
    .eof_in      (eof_in),
    .chainId_in  (chainId_in),
    .configId    (configId),
    .configData  (configData),
    .vector_in   (vector_in),
    .vector_out  (vector_out),
    .chainId_out (chainId_out),
    .valid_out   (valid_out),
    .bof_out     (bof_out),
    .eof_out     (eof_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t splat(input int unsigned x);
    vec_t r;
    for (int l = 0; l < 8; l++) r[l] = x;
    return r;
  endfunction

  function automatic vec_t seq18();
    vec_t r;
    for (int l = 0; l < 8; l++) r[l] = 32'(l + 1);
    return r;
  endfunction

  function automatic vec_t two(input int unsigned a,
                               input int unsigned b);
    vec_t r = '0;
    r[0] = a;
    r[1] = b;
    return r;
  endfunction

  function automatic vrec_t mk(input logic v, input logic [1:0] ch,
                               input logic b, input logic e,
                               input vec_t vec, input logic ev,
                               input vec_t evec, input logic eb,
                               input logic ee);
    vrec_t r;
    r.v = v; r.ch = ch; r.b = b; r.e = e; r.vec = vec;
    r.ev = ev; r.evec = evec; r.eb = eb; r.ee = ee;
    return r;
  endfunction

  // Reference model: each chain keeps the vectors folded since the
  // last start; the window result is reduced from them at emit.
  int unsigned m_op[4];
  int unsigned m_win[4];
  int unsigned m_frames[4];
  vec_t        m_q[4][$];
  logic        e_valid, e_bof, e_eof;
  logic [1:0]  e_ch;
  vec_t        e_vec;

  function automatic vec_t fold_q(input int c);
    vec_t r = '0;
    foreach (m_q[c][k]) begin
      for (int l = 0; l < 8; l++) begin
        if (m_op[c] == 2)
          r[l] = (m_q[c][k][l] > r[l]) ? m_q[c][k][l] : r[l];
        else
          r[l] = r[l] + m_q[c][k][l];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_op[c] = 0; m_win[c] = 1; m_frames[c] = 0;
      m_q[c].delete();
    end
    e_valid = 0; e_bof = 0; e_eof = 0; e_ch = 0; e_vec = '0;
  endtask

  task automatic model_cfg(input int idx, input logic [7:0] b);
    int c;
    if (idx < 8) begin
      c = idx % 4;
      if (idx < 4) m_op[c] = b;
      else m_win[c] = b;
      m_frames[c] = 0;
      m_q[c].delete();
    end
  endtask

  task automatic model_step(input logic v, input logic [1:0] ch,
                            input logic b, input logic e,
                            input vec_t vec);
    int unsigned w;
    e_valid = 0;
    if (!v) return;
    if (m_op[ch] != 1 && m_op[ch] != 2) begin
      e_valid = 1; e_vec = vec; e_bof = b; e_eof = e; e_ch = ch;
      return;
    end
    if (b && m_frames[ch] == 0) m_q[ch].delete();
    m_q[ch].push_back(vec);
    if (e) begin
      m_frames[ch]++;
      w = (m_win[ch] == 0) ? 1 : m_win[ch];
      if (m_frames[ch] >= w) begin
        e_valid = 1; e_vec = fold_q(ch);
        e_bof = 1; e_eof = 1; e_ch = ch;
        m_q[ch].delete();
        m_frames[ch] = 0;
      end
    end
  endtask

  task automatic apply(input logic v, input logic [1:0] ch,
                       input logic b, input logic e,
                       input vec_t vec);
    valid_in = v; chainId_in = ch; bof_in = b; eof_in = e;
    vector_in = vec;
    model_step(v, ch, b, e, vec);
    @(posedge clk);
    #1;
  endtask

  task automatic do_config(input logic [7:0] bytes [10],
                           input int n);
    tracing = 0;
    configId = 8'd1;
    for (int i = 0; i < n; i++) begin
      configData = bytes[i];
      valid_in = 1; chainId_in = 2'(i); bof_in = 1; eof_in = 1;
      vector_in = splat($urandom);
      @(posedge clk);
      #1;
      model_cfg(i, bytes[i]);
      e_valid = 0;
      check("cfg_valid_low", valid_out, 1'b0);
    end
    configId = 8'd0;
    configData = 8'd0;
    @(posedge clk);
    #1;
    check("cfg_end_valid_low", valid_out, 1'b0);
    tracing = 1;
    valid_in = 0;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_valid"}, valid_out, e_valid);
    check({tag, "_vec"}, vector_out, e_vec);
    if (e_valid) begin
      check({tag, "_ch"}, chainId_out, e_ch);
      check({tag, "_bof"}, bof_out, e_bof);
      check({tag, "_eof"}, eof_out, e_eof);
    end
  endtask

  vrec_t tbl[12];
  logic [7:0] cb [10];

  initial begin
    tbl[0]  = mk(1, 0, 1, 1, seq18(), 1, seq18(), 1, 1);
    tbl[1]  = mk(1, 1, 1, 0, splat(2), 0, '0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, splat(3), 0, '0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 1, splat(5), 1, splat(10), 1, 1);
    tbl[4]  = mk(1, 3, 1, 1, splat(4), 0, '0, 0, 0);
    tbl[5]  = mk(1, 3, 1, 1, splat(6), 1, splat(10), 1, 1);
    tbl[6]  = mk(1, 2, 1, 0, two(9, 0), 0, '0, 0, 0);
    tbl[7]  = mk(1, 3, 1, 1, splat(32'hFFFF_FFFF), 0, '0, 0, 0);
    tbl[8]  = mk(1, 2, 0, 1, two(3, 7), 1, two(9, 7), 1, 1);
    tbl[9]  = mk(1, 3, 1, 1, splat(2), 1, splat(1), 1, 1);
    tbl[10] = mk(0, 0, 0, 0, '0, 0, '0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, splat(42), 1, splat(42), 0, 0);

    resetn = 0; tracing = 1; valid_in = 0; bof_in = 0; eof_in = 0;
    chainId_in = 0; configId = 0; configData = 0; vector_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid_out, 1'b0);
    check("rst_vec", vector_out, '0);
    check("rst_ch", chainId_out, 2'd0);
    check("rst_bof", bof_out, 1'b0);
    check("rst_eof", eof_out, 1'b0);
    resetn = 1;
    model_reset();

    apply(1, 1, 1, 1, seq18());
    check("init_pass_valid", valid_out, 1'b1);
    check("init_pass_vec", vector_out, seq18());
    check("init_pass_ch", chainId_out, 2'd1);

    cb = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd0, 8'd0};
    do_config(cb, 8);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].ch, tbl[i].b, tbl[i].e, tbl[i].vec);
      check($sformatf("tbl%0d_valid", i), valid_out, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_vec", i), vector_out, tbl[i].evec);
        check($sformatf("tbl%0d_ch", i), chainId_out, tbl[i].ch);
        check($sformatf("tbl%0d_bof", i), bof_out, tbl[i].eb);
        check($sformatf("tbl%0d_eof", i), eof_out, tbl[i].ee);
      end
    end

    apply(1, 3, 1, 1, splat(7));
    check("partial_ch3_valid", valid_out, 1'b0);
    cb = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0,
           8'h55, 8'h66};
    do_config(cb, 10);
    apply(1, 3, 1, 1, splat(5));
    check("cfg_ch3_cleared_valid", valid_out, 1'b1);
    check("cfg_ch3_cleared_vec", vector_out, splat(5));
    apply(1, 1, 1, 1, two(4, 11));
    check("cfg_ch1_max_w0_valid", valid_out, 1'b1);
    check("cfg_ch1_max_w0_vec", vector_out, two(4, 11));
    apply(1, 2, 0, 0, splat(8));
    check("cfg_ch2_pass_valid", valid_out, 1'b1);
    check("cfg_ch2_pass_eof", eof_out, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 1, 1, splat(1));
      check($sformatf("cfg_ch0_w3_f%0d_valid", k), valid_out,
            (k == 2) ? 1'b1 : 1'b0);
    end
    check("cfg_ch0_w3_vec", vector_out, splat(3));

    cb = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd0, 8'd0};
    do_config(cb, 8);
    apply(1, 0, 1, 1, splat(3));
    check("rst_mid_first_valid", valid_out, 1'b0);
    resetn = 0;
    valid_in = 1; chainId_in = 0; bof_in = 1; eof_in = 1;
    vector_in = splat(3);
    @(posedge clk);
    #1;
    check("rst_mid_valid", valid_out, 1'b0);
    check("rst_mid_vec", vector_out, '0);
    check("rst_mid_ch", chainId_out, 2'd0);
    resetn = 1;
    model_reset();
    apply(1, 0, 1, 1, seq18());
    check("rst_fw_pass_valid", valid_out, 1'b1);
    check("rst_fw_pass_vec", vector_out, seq18());
    do_config(cb, 8);
    apply(1, 0, 1, 1, splat(4));
    check("rst_new_f1_valid", valid_out, 1'b0);
    apply(1, 0, 1, 1, splat(5));
    check("rst_new_f2_valid", valid_out, 1'b1);
    check("rst_new_f2_vec", vector_out, splat(9));

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++)
        cb[i] = 8'((i < 4) ? $urandom_range(0, 3) : $urandom_range(0, 3));
      cb[8] = 0; cb[9] = 0;
      do_config(cb, 8);
      for (int k = 0; k < 250; k++) begin
        vec_t rv;
        logic big;
        big = ($urandom % 2) == 0;
        for (int l = 0; l < 8; l++)
          rv[l] = big ? $urandom : $urandom_range(0, 15);
        apply(($urandom % 4) != 0, 2'($urandom),
              ($urandom % 3) == 0, ($urandom % 3) == 0, rv);
        cmp_model("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vector_chain_accumulator.md
# vector_chain_accumulator

Per-chain vector accumulator placed directly downstream of the filter-reduce stage. It consumes per-vector histogram/count vectors and folds them (sum or max) across the vectors of a frame, and optionally across several frames. It emits one vector per accumulation window, so the trace buffer stores one summary per window rather than every vector. The block is firmware-configurable per chain through the shared `configId`/`configData` byte stream, and is bypassable per chain.

## Interface
- `N`, 8: vector lanes
- `DATA_WIDTH`, 32: lane width
- `MAX_CHAINS`, 4: number of independent chains
- `PERSONAL_CONFIG_ID`, 1: config stream ID owned by this block
- `INITIAL_FIRMWARE_OP`, all 0: per-chain op byte loaded at reset
- `INITIAL_FIRMWARE_WINDOW`, all 1: per-chain frames-per-emit loaded at reset
- `clk`  in  1  clock
- `resetn`  in  1  reset; synchronous, active-low
- `tracing`  in  1  1 = process data, 0 = configuration mode
- `valid_in`, `bof_in`, `eof_in`  in  1 each  input vector valid, begin-of-frame, end-of-frame
- `chainId_in`  in  $clog2(MAX_CHAINS)  chain of input vector
- `configId`, `configData`  in  8 each  configuration stream
- `vector_in`  in  N×DATA_WIDTH  input vector
- `vector_out`  out  N×DATA_WIDTH  output vector
- `chainId_out`  out  $clog2(MAX_CHAINS)  chain of output vector
- `valid_out`, `bof_out`, `eof_out`  out  1 each  output qualifiers

## Operation
- Per-chain state:
  - `op` byte: 0 = PASS, 1 = SUM, 2 = MAX; any other value behaves as PASS.
  - `window` byte: value 0 is treated as 1.
  - Frame counter, 8 bits.
  - Accumulator, N×DATA_WIDTH.
- PASS: the input vector and its flags are registered to the output unchanged. The chain's accumulator is not touched.
- SUM/MAX, on `valid_in` with `tracing`=1:
  - `start` = `bof_in` && frame counter==0. On start, the new accumulator value is `vector_in`. Otherwise it is acc+`vector_in` (SUM) or lane-wise unsigned max (MAX).
  - SUM is unsigned modulo 2^DATA_WIDTH and wraps silently.
  - On `eof_in`, the frame counter increments. If the incremented value reaches `window`:
    - Emit `vector_out` = new accumulator value, with `valid_out`=`bof_out`=`eof_out`=1.
    - Clear the frame counter.
    - Clear the accumulator to 0.
  - Non-emitting inputs produce `valid_out`=0.
  - `bof_in`&`eof_in` in the same cycle is a single-vector frame: start and end apply together.
  - Vectors arriving outside an open frame (e.g. after reset, before any `bof_in`) fold into the current accumulator, which starts at 0.
- `tracing`=0:
  - `valid_out` is 0. Data inputs are ignored and accumulators and counters hold.
  - While `configId`==`PERSONAL_CONFIG_ID`, `byte_counter` increments once per cycle. Otherwise it is 0.
  - Bytes 0..MAX_CHAINS-1 write `op[c]`. Bytes MAX_CHAINS..2·MAX_CHAINS-1 write `window[c]`. Later bytes are ignored.
  - Any write to chain c clears its accumulator and frame counter.
- Reset (`resetn`=0 at a clock edge):
  - All outputs go to 0.
  - Accumulators, counters and `byte_counter` go to 0.
  - Firmware reloads from the INITIAL parameters.
  - Reset overrides all other activity in the same cycle, including mid-window; a partial window is discarded.

## Timing
- Latency is 1 cycle from `valid_in` to `valid_out` for both emit and PASS. The output is registered.
- There is no backpressure: one vector is accepted per cycle, every cycle.
- Back-to-back vectors on the same chain see the previous cycle's accumulator update. Because state is registered, no forwarding hazard exists.
- Interleaved chains are fully independent.
- `chainId_out` is `chainId_in` delayed by 1 cycle.
- Outputs hold their last value when `valid_out`=0, except `valid_out` itself.

## Structure
- Shared package entries:
  - Op encodings `OP_PASS`=0, `OP_SUM`=1, `OP_MAX`=2.
  - Config offsets `CFG_OP_BASE`=0 and `CFG_WINDOW_BASE`=MAX_CHAINS.
- Sub-module `lane_combine`: combinational, N lanes. Inputs are the accumulator, the input vector, op and start. Output is the new accumulator value.
- Accumulators are implemented as a register array, MAX_CHAINS×N×DATA_WIDTH.

## Test plan
- **PASS:** chain 0, op=0, send vector {1..8} with bof=eof=1. Expect {1..8}, bof=eof=1, chainId_out=0 one cycle later.
- **SUM, window 1:** chain 1, op=1, window=1. Send a 3-vector frame of all-2, all-3, all-5. Expect exactly one output, all-10, on the cycle after eof; no output for the first two vectors.
- **SUM, window 2:** op=1, window=2. Send two single-vector frames of all-4 and all-6. Expect one output, all-10, after the second frame. Also check wrap: 0xFFFFFFFF + 2 gives 1.
- **MAX with interleaving:** chain 2 op=2 and chain 3 op=1, interleaved each cycle. Chain 2 receives {9,0,...} then {3,7,...}; expect {9,7,...}. Chain 3 sums independently.
- **Config:** `tracing`=0, `configId`=1, bytes {1,2,0,1,3,0,0,0} then `configId`=0. Expect op={1,2,0,1}, window={3,0,0,0} (0 behaves as 1), `valid_out`=0 throughout, and the affected accumulators cleared.
- **Reset mid-window:** SUM window=2, one frame accumulated, then `resetn`=0 for 1 cycle. Expect outputs 0 and firmware back to the INITIAL parameters. A new frame then emits only its own sum once the window completes.
